// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Buffers wide ALU results (with their error flag) in a small FIFO and
// replays each one as two narrow beats, low half first, on a valid/ready
// bus. Also keeps a saturating count of errored results for status readout.
// All outputs are derived from registers only, so there is no combinational
// path from out_ready back to res_ready.

module alu_result_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        res_valid,
    input  logic [2*DATA_WIDTH-1:0]     res_data,
    input  logic                        res_err,
    output logic                        res_ready,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    output logic                        out_err,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic [CNT_WIDTH-1:0]        err_count,
    input  logic                        clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RES_W = 2 * DATA_WIDTH;
    localparam int ENT_W = RES_W + 1;

    localparam logic [LVL_W-1:0]     FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } rd_state_t;

    // Entry layout: {err, result}
    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    rd_state_t            state;
    logic [CNT_WIDTH-1:0] err_cnt;

    logic                 push;
    logic                 beat;
    logic                 pop;
    logic                 err_push;
    logic [ENT_W-1:0]     head;

    // Saturating increment for the error counter; sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            return CNT_MAX;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // Handshake decode; a full FIFO refuses input even if the head pops this cycle.
    always_comb begin
        res_ready = (level != FULL_LEVEL);
        out_valid = (level != '0);
        push      = res_valid && res_ready;
        beat      = out_valid && out_ready;
        pop       = beat && (state == ST_HI);
        err_push  = push && res_err;
        head      = mem[rd_ptr];
    end

    // Present the selected half of the head entry; zero when nothing is stored.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        out_err  = 1'b0;
        if (out_valid) begin
            out_err = head[ENT_W-1];
            if (state == ST_HI) begin
                out_data = head[RES_W-1:DATA_WIDTH];
                out_last = 1'b1;
            end else begin
                out_data = head[DATA_WIDTH-1:0];
            end
        end
    end

    // Storage array: data only, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {res_err, res_data};
        end
    end

    // Pointers, occupancy and the two-beat read FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            state  <= ST_LO;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            case (state)
                ST_LO: if (beat) state <= ST_HI;
                ST_HI: if (beat) state <= ST_LO;
                default: state <= ST_LO;
            endcase
        end
    end

    // Errored-result counter; a clear that coincides with an errored push leaves 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= err_push ? CNT_WIDTH'(1) : '0;
        end else if (err_push) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

    assign fifo_level = level;
    assign err_count  = err_cnt;

endmodule
